// File: rtl/elevator_pkg.sv
// ============================================================================
// Module : elevator_pkg
// Brief  : Shared types and defaults for the elevator queue / car controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package elevator_pkg;

  localparam int DEF_FLOOR_COUNT = 7;
  localparam int DEF_FLOOR_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    CLEAR = 2'd2,
    DOOR  = 2'd3
  } car_state_t;

  // One spare bit above the larger period so the saturating timer never aliases.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/elevator_req_scan.sv
// ============================================================================
// Module : elevator_req_scan
// Brief  : Splits the pending-request mask into here / above / below a floor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module elevator_req_scan
  import elevator_pkg::*;
#(
  parameter int FLOOR_COUNT = DEF_FLOOR_COUNT,
  parameter int FLOOR_W     = DEF_FLOOR_W
) (
  input  logic [FLOOR_COUNT-1:0] queue_status,
  input  logic [FLOOR_W-1:0]     floor_idx,
  output logic                   here,
  output logic                   above,
  output logic                   below
);

  always_comb begin
    here  = 1'b0;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOOR_COUNT; i++) begin
      if (FLOOR_W'(i) == floor_idx) here  = here  | queue_status[i];
      if (FLOOR_W'(i) >  floor_idx) above = above | queue_status[i];
      if (FLOOR_W'(i) <  floor_idx) below = below | queue_status[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/elevator_car_ctrl.sv
// ============================================================================
// Module : elevator_car_ctrl
// Brief  : LOOK-policy car motion / door controller fed by elevator_queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int FLOOR_COUNT   = DEF_FLOOR_COUNT,
  parameter int FLOOR_W       = DEF_FLOOR_W,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [FLOOR_COUNT-1:0] queue_status,
  output logic                   q_r_nwr,
  output logic                   q_deassert,
  output logic [FLOOR_W-1:0]     q_floor,
  output logic [FLOOR_W-1:0]     current_floor,
  output logic                   motor_up,
  output logic                   motor_down,
  output logic                   door_open,
  output logic                   dir_up
);

  localparam int                 CNT_W       = cnt_width(TRAVEL_CYCLES, DOOR_CYCLES);
  localparam logic [CNT_W-1:0]   TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(FLOOR_COUNT - 1);

  car_state_t           state_q,  state_d;
  logic [FLOOR_W-1:0]   floor_q,  floor_d;
  logic                 dir_up_q, dir_up_d;
  logic [CNT_W-1:0]     timer_q,  timer_d;

  logic                 here, above, below;
  logic                 here_nx, above_nx, below_nx;
  logic                 at_end;
  logic [FLOOR_W-1:0]   next_floor;
  logic [CNT_W-1:0]     timer_inc;

  assign at_end     = dir_up_q ? (floor_q == TOP_FLOOR) : (floor_q == '0);
  assign next_floor = at_end   ? floor_q
                    : dir_up_q ? floor_q + 1'b1 : floor_q - 1'b1;
  assign timer_inc  = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  elevator_req_scan #(
    .FLOOR_COUNT (FLOOR_COUNT),
    .FLOOR_W     (FLOOR_W)
  ) u_scan_here (
    .queue_status (queue_status),
    .floor_idx    (floor_q),
    .here         (here),
    .above        (above),
    .below        (below)
  );

  // Second scan looks at the floor being arrived at, so arrival decisions need no extra cycle.
  elevator_req_scan #(
    .FLOOR_COUNT (FLOOR_COUNT),
    .FLOOR_W     (FLOOR_W)
  ) u_scan_next (
    .queue_status (queue_status),
    .floor_idx    (next_floor),
    .here         (here_nx),
    .above        (above_nx),
    .below        (below_nx)
  );

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_up_d = dir_up_q;
    timer_d  = timer_inc;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (here) begin
          state_d = CLEAR;
        end else if (above && (dir_up_q || !below)) begin
          state_d  = MOVE;
          dir_up_d = 1'b1;
        end else if (below) begin
          state_d  = MOVE;
          dir_up_d = 1'b0;
        end
      end
      MOVE: begin
        if (timer_q == TRAVEL_LAST) begin
          timer_d = '0;
          if (at_end) begin
            state_d = IDLE;
          end else begin
            floor_d = next_floor;
            if (here_nx) begin
              state_d = CLEAR;
            end else if (!(dir_up_q ? above_nx : below_nx)) begin
              state_d = IDLE;
            end
          end
        end
      end
      CLEAR: begin
        timer_d = '0;
        state_d = DOOR;
      end
      DOOR: begin
        // The queue bit cleared on entry has settled by now; a set bit is a fresh hall call.
        if (timer_q == DOOR_LAST) begin
          timer_d = '0;
          state_d = here ? CLEAR : IDLE;
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      floor_q  <= '0;
      dir_up_q <= 1'b1;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_up_q <= dir_up_d;
      timer_q  <= timer_d;
    end
  end

  assign current_floor = floor_q;
  assign dir_up        = dir_up_q;
  assign motor_up      = (state_q == MOVE) &&  dir_up_q;
  assign motor_down    = (state_q == MOVE) && !dir_up_q;
  assign door_open     = (state_q == DOOR);
  assign q_r_nwr       = (state_q != CLEAR);
  assign q_deassert    = (state_q == CLEAR);
  assign q_floor       = (state_q == CLEAR) ? floor_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_elevator_car_ctrl.sv
// ============================================================================
// Module : tb_elevator_car_ctrl
// Brief  : Directed self-checking bench with a behavioural elevator_queue model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_elevator_car_ctrl;

  localparam int FC = 7;
  localparam int FW = 3;
  localparam int TC = 4;
  localparam int DC = 8;
  localparam logic [11:0] RESET_VEC = 12'b000_1_1_0_000_0_0_0;

  logic          clk = 1'b0;
  logic          reset;
  logic [FC-1:0] queue_status;
  logic [FC-1:0] call_set;
  logic [FC-1:0] clr_mask;
  logic          q_r_nwr, q_deassert, motor_up, motor_down, door_open, dir_up;
  logic [FW-1:0] q_floor, current_floor;
  logic [11:0]   obs_vec;

  int n_checks = 0;
  int n_fail   = 0;
  int mu_cnt, md_cnt, door_cnt, clr_cnt, bad_cnt, max_floor, prev_floor;
  int clr_floor [4];

  always #5 clk = ~clk;

  elevator_car_ctrl #(
    .FLOOR_COUNT   (FC),
    .FLOOR_W       (FW),
    .TRAVEL_CYCLES (TC),
    .DOOR_CYCLES   (DC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .queue_status  (queue_status),
    .q_r_nwr       (q_r_nwr),
    .q_deassert    (q_deassert),
    .q_floor       (q_floor),
    .current_floor (current_floor),
    .motor_up      (motor_up),
    .motor_down    (motor_down),
    .door_open     (door_open),
    .dir_up        (dir_up)
  );

  assign obs_vec  = {current_floor, dir_up, q_r_nwr, q_deassert, q_floor,
                     motor_up, motor_down, door_open};
  assign clr_mask = (!q_r_nwr && q_deassert) ? (FC'(1) << q_floor) : '0;

  // Queue model: new calls are set, a write-back deassert clears; clear wins on a tie.
  always @(posedge clk or posedge reset) begin
    if (reset) queue_status <= '0;
    else       queue_status <= (queue_status | call_set) & ~clr_mask;
  end

  task automatic clear_obs();
    mu_cnt = 0; md_cnt = 0; door_cnt = 0; clr_cnt = 0; bad_cnt = 0;
    max_floor  = int'(current_floor);
    prev_floor = int'(current_floor);
    for (int k = 0; k < 4; k++) clr_floor[k] = -1;
  endtask

  // Samples n negedges; on sample index at_cycle it drives call mask m for one posedge.
  task automatic observe(input int n, input int at_cycle, input logic [FC-1:0] m);
    int f;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      f = int'(current_floor);
      if (motor_up)   mu_cnt++;
      if (motor_down) md_cnt++;
      if (door_open)  door_cnt++;
      if (!q_r_nwr) begin
        if (clr_cnt < 4) clr_floor[clr_cnt] = int'(q_floor);
        clr_cnt++;
      end
      if ((motor_up && motor_down) || (door_open && (motor_up || motor_down))) bad_cnt++;
      if ((f - prev_floor > 1) || (prev_floor - f > 1) || f > FC - 1) bad_cnt++;
      if (f > max_floor) max_floor = f;
      prev_floor = f;
      call_set = (i == at_cycle) ? m : '0;
    end
    call_set = '0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_vec !== RESET_VEC) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs_vec, RESET_VEC);
    end
    reset = 1'b0;
    clear_obs();
    observe(30, -1, '0);
    n_checks++;
    if (mu_cnt + md_cnt + door_cnt + clr_cnt !== 0) begin
      n_fail++; $display("FAIL idle_activity: got %0d active samples expected 0",
                         mu_cnt + md_cnt + door_cnt + clr_cnt);
    end
    n_checks++;
    if (obs_vec !== RESET_VEC) begin
      n_fail++; $display("FAIL idle_outputs: got %b expected %b", obs_vec, RESET_VEC);
    end
  endtask

  task automatic test_call_floor3();
    clear_obs();
    observe(40, 0, 7'b0001000);
    n_checks++;
    if (mu_cnt !== 3 * TC || md_cnt !== 0) begin
      n_fail++; $display("FAIL f3_motor: got up=%0d down=%0d expected up=12 down=0", mu_cnt, md_cnt);
    end
    n_checks++;
    if (clr_cnt !== 1 || clr_floor[0] !== 3) begin
      n_fail++; $display("FAIL f3_clear: got n=%0d floor=%0d expected n=1 floor=3",
                         clr_cnt, clr_floor[0]);
    end
    n_checks++;
    if (door_cnt !== DC) begin
      n_fail++; $display("FAIL f3_door: got %0d expected %0d", door_cnt, DC);
    end
    n_checks++;
    if (current_floor !== 3'd3 || queue_status !== 7'b0 || max_floor !== 3 || bad_cnt !== 0) begin
      n_fail++; $display("FAIL f3_final: got floor=%0d queue=%b max=%0d bad=%0d expected 3 0000000 3 0",
                         current_floor, queue_status, max_floor, bad_cnt);
    end
  endtask

  task automatic test_look_sweep();
    clear_obs();
    observe(70, 0, 7'b0100010);
    n_checks++;
    if (mu_cnt !== 2 * TC || md_cnt !== 4 * TC) begin
      n_fail++; $display("FAIL sweep_motor: got up=%0d down=%0d expected up=8 down=16", mu_cnt, md_cnt);
    end
    n_checks++;
    if (clr_cnt !== 2 || clr_floor[0] !== 5 || clr_floor[1] !== 1) begin
      n_fail++; $display("FAIL sweep_order: got n=%0d first=%0d second=%0d expected 2 5 1",
                         clr_cnt, clr_floor[0], clr_floor[1]);
    end
    n_checks++;
    if (current_floor !== 3'd1 || dir_up !== 1'b0 || door_cnt !== 2 * DC || max_floor !== 5) begin
      n_fail++; $display("FAIL sweep_final: got floor=%0d dir_up=%b door=%0d max=%0d expected 1 0 16 5",
                         current_floor, dir_up, door_cnt, max_floor);
    end
    n_checks++;
    if (queue_status !== 7'b0 || bad_cnt !== 0) begin
      n_fail++; $display("FAIL sweep_queue: got queue=%b bad=%0d expected 0000000 0", queue_status, bad_cnt);
    end
  endtask

  task automatic test_call_here();
    clear_obs();
    observe(25, 0, 7'b0000100);
    n_checks++;
    if (current_floor !== 3'd2 || mu_cnt !== TC) begin
      n_fail++; $display("FAIL here_setup: got floor=%0d up=%0d expected 2 4", current_floor, mu_cnt);
    end
    clear_obs();
    observe(2, 0, 7'b0000100);
    n_checks++;
    if (clr_cnt !== 0) begin
      n_fail++; $display("FAIL here_latency: got %0d early clears expected 0", clr_cnt);
    end
    @(negedge clk);
    n_checks++;
    if ({q_r_nwr, q_deassert, q_floor, motor_up, motor_down, door_open} !== 8'b0_1_010_000) begin
      n_fail++; $display("FAIL here_clear: got %b expected 01010000",
                         {q_r_nwr, q_deassert, q_floor, motor_up, motor_down, door_open});
    end
    clear_obs();
    observe(20, -1, '0);
    n_checks++;
    if (door_cnt !== DC || mu_cnt + md_cnt !== 0 || clr_cnt !== 0 || queue_status !== 7'b0) begin
      n_fail++; $display("FAIL here_door: got door=%0d motor=%0d clr=%0d queue=%b expected 8 0 0 0000000",
                         door_cnt, mu_cnt + md_cnt, clr_cnt, queue_status);
    end
  endtask

  task automatic test_door_extend();
    clear_obs();
    observe(6, 0, 7'b0000100);
    observe(40, 0, 7'b0000100);
    n_checks++;
    if (clr_cnt !== 2 || clr_floor[0] !== 2 || clr_floor[1] !== 2) begin
      n_fail++; $display("FAIL extend_clear: got n=%0d floors=%0d,%0d expected 2 2,2",
                         clr_cnt, clr_floor[0], clr_floor[1]);
    end
    n_checks++;
    if (door_cnt !== 2 * DC || mu_cnt + md_cnt !== 0 || queue_status !== 7'b0) begin
      n_fail++; $display("FAIL extend_door: got door=%0d motor=%0d queue=%b expected 16 0 0000000",
                         door_cnt, mu_cnt + md_cnt, queue_status);
    end
  endtask

  task automatic test_top_floor();
    clear_obs();
    observe(50, 0, 7'b1000000);
    n_checks++;
    if (current_floor !== 3'd6 || max_floor !== 6 || mu_cnt !== 4 * TC || clr_floor[0] !== 6 ||
        bad_cnt !== 0) begin
      n_fail++; $display("FAIL top_floor: got floor=%0d max=%0d up=%0d clr=%0d bad=%0d expected 6 6 16 6 0",
                         current_floor, max_floor, mu_cnt, clr_floor[0], bad_cnt);
    end
  endtask

  task automatic test_reset_mid_move();
    int  waited;
    clear_obs();
    observe(2, 0, 7'b0000001);
    waited = 0;
    while (!(current_floor == 3'd4 && motor_down) && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (waited >= 60) begin
      n_fail++; $display("FAIL mid_move_reach: got floor=%0d expected 4 while moving within 60 cycles",
                         current_floor);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs_vec !== RESET_VEC) begin
      n_fail++; $display("FAIL mid_move_reset: got %b expected %b", obs_vec, RESET_VEC);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_obs();
    observe(20, -1, '0);
    n_checks++;
    if (obs_vec !== RESET_VEC || mu_cnt + md_cnt + door_cnt + clr_cnt !== 0) begin
      n_fail++; $display("FAIL post_reset_idle: got %b active=%0d expected %b 0",
                         obs_vec, mu_cnt + md_cnt + door_cnt + clr_cnt, RESET_VEC);
    end
  endtask

  initial begin
    reset    = 1'b1;
    call_set = '0;
    test_reset();
    test_call_floor3();
    test_look_sweep();
    test_call_here();
    test_door_extend();
    test_top_floor();
    test_reset_mid_move();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
